// File: rtl/gate_resp_checker_if.sv
// Response handshake carrying one sampled gate response: applied inputs plus
// the seven gate outputs, qualified by valid/ready.
interface gate_resp_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_a;
  logic       in_b;
  logic [6:0] in_resp;

  modport master (output in_valid, in_a, in_b, in_resp, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_resp, output in_ready);
endinterface

// File: rtl/gate_resp_checker.sv
// Receiving end of the exhaustive gate test: checks each response against the
// gate truth table, counts errors, records the first failure, flags stalls.
module gate_resp_checker #(
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  gate_resp_checker_if.slave rsp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               first_fail_valid,
  output logic [1:0]         first_fail_vec,
  output logic [6:0]         first_fail_mask
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             a_p0;
  logic             b_p0;
  logic [6:0]       resp_p0;
  logic [TMR_W-1:0] idle_tmr;
  logic             xfer;
  logic             run_start;
  logic             tmo_hit;
  logic             last_vec;
  logic [6:0]       mask_p1;
  logic [CNT_W-1:0] vec_nxt;
  logic [CNT_W-1:0] err_nxt;

  function automatic logic [6:0] gate_expect(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign xfer      = rsp.in_valid && rsp.in_ready;
  assign run_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign tmo_hit   = (TIMEOUT != 0) && (state == S_WAIT) && !xfer &&
                     (idle_tmr == TMR_W'(TIMEOUT - 1));

  // Check stage: compare the captured response against the truth table
  assign mask_p1  = resp_p0 ^ gate_expect(a_p0, b_p0);
  assign vec_nxt  = vec_count + CNT_W'(1);
  assign err_nxt  = (mask_p1 != '0) ? sat_inc(err_count) : err_count;
  assign last_vec = (vec_nxt == CNT_W'(NUM_VEC));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rsp.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        rsp.in_ready = 1'b1;
        busy         = 1'b1;
        if (xfer)         state_nxt = S_CHECK;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = last_vec ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done = 1'b1;
        if (run_start) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture stage (WAIT) and result update (CHECK)
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0             <= 1'b0;
      b_p0             <= 1'b0;
      resp_p0          <= '0;
      idle_tmr         <= '0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      vec_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_mask  <= '0;
    end else begin
      if (run_start) begin
        idle_tmr         <= '0;
        pass             <= 1'b0;
        timeout          <= 1'b0;
        vec_count        <= '0;
        err_count        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
        first_fail_mask  <= '0;
      end
      if (state == S_WAIT) begin
        if (xfer) begin
          a_p0    <= rsp.in_a;
          b_p0    <= rsp.in_b;
          resp_p0 <= rsp.in_resp;
        end else if (tmo_hit) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
        end else if (TIMEOUT != 0) begin
          idle_tmr <= idle_tmr + TMR_W'(1);
        end
      end
      if (state == S_CHECK) begin
        vec_count <= vec_nxt;
        err_count <= err_nxt;
        idle_tmr  <= '0;
        if ((mask_p1 != '0) && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= {a_p0, b_p0};
          first_fail_mask  <= mask_p1;
        end
        if (last_vec) pass <= (err_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: table rows, hand-written corner sequences and
// randomized runs checked against a lookup-table reference model.
module tb_gate_resp_checker;
  localparam int NUM_VEC = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic             first_fail_valid;
  logic [1:0]       first_fail_vec;
  logic [6:0]       first_fail_mask;

  gate_resp_checker_if rif();

  gate_resp_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rsp              (rif),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .timeout          (timeout),
    .vec_count        (vec_count),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .first_fail_mask  (first_fail_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] ab [4];
    logic [6:0] rs [4];
    logic [7:0] err;
    logic       ffv;
    logic [1:0] ffvec;
    logic [6:0] ffmask;
    logic       pass;
  } row_t;

  row_t tbl [6];

  function automatic logic [6:0] golden_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 7'h1D;
      2'b01:   return 7'h3A;
      2'b10:   return 7'h2A;
      default: return 7'h61;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab, input logic [6:0] rs);
    rif.in_a    = ab[1];
    rif.in_b    = ab[0];
    rif.in_resp = rs;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {rif.in_ready, busy, done, pass, timeout, vec_count, err_count,
                 first_fail_valid, first_fail_vec, first_fail_mask}, 32'h0);
  endtask

  // Waits for in_ready, idles gap WAIT cycles, then transfers one response.
  task automatic send_gap(input logic [1:0] ab, input logic [6:0] rs, input int gap);
    int guard = 0;
    rif.in_valid = 1'b0;
    while (!rif.in_ready && !done && guard < 8) begin
      tick();
      guard++;
    end
    if (done) return;
    check("send.ready", rif.in_ready, 1'b1);
    for (int k = 0; k < gap; k++) begin
      tick();
      if (done) return;
    end
    drive(ab, rs);
    rif.in_valid = 1'b1;
    tick();
    rif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (!done && guard < 40) begin
      tick();
      guard++;
    end
    check(name, done, 1'b1);
  endtask

  task automatic apply_row(input int r);
    logic [7:0] rdy;
    rdy = '0;
    start_pulse();
    rif.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[r].ab[i], tbl[r].rs[i]);
      rdy = {rdy[6:0], rif.in_ready};
      tick();
      rdy = {rdy[6:0], rif.in_ready};
      tick();
    end
    check($sformatf("row%0d.ready_pat", r), rdy, 8'hAA);
    check($sformatf("row%0d.done", r), done, 1'b1);
    check($sformatf("row%0d.busy", r), busy, 1'b0);
    check($sformatf("row%0d.pass", r), pass, tbl[r].pass);
    check($sformatf("row%0d.vec", r), vec_count, 8'd4);
    check($sformatf("row%0d.err", r), err_count, tbl[r].err);
    check($sformatf("row%0d.ffv", r), first_fail_valid, tbl[r].ffv);
    check($sformatf("row%0d.ffvec", r), first_fail_vec, tbl[r].ffvec);
    check($sformatf("row%0d.ffmask", r), first_fail_mask, tbl[r].ffmask);
    // in_valid still high in DONE must not be consumed
    tick();
    tick();
    check($sformatf("row%0d.done_hold", r), {done, rif.in_ready, vec_count}, {1'b1, 1'b0, 8'd4});
    rif.in_valid = 1'b0;
  endtask

  task automatic random_run(input int run);
    logic [1:0] ab [4];
    logic [6:0] rs [4];
    int         gap [4];
    int         big;
    int         exp_vec;
    int         exp_err;
    logic       exp_to;
    logic       exp_ffv;
    logic [1:0] exp_ffvec;
    logic [6:0] exp_ffmask;
    int         sel;

    big = (run % 5 == 4) ? int'($urandom_range(0, 3)) : -1;
    for (int i = 0; i < 4; i++) begin
      ab[i] = 2'($urandom_range(0, 3));
      sel   = int'($urandom_range(0, 3));
      if (sel < 2)       rs[i] = golden_of(ab[i]);
      else if (sel == 2) rs[i] = golden_of(ab[i]) ^ 7'(1 << $urandom_range(0, 6));
      else               rs[i] = 7'($urandom_range(0, 127));
      gap[i] = (i == big) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3))
                          : int'($urandom_range(0, 3));
    end

    exp_vec = 0; exp_err = 0; exp_to = 1'b0;
    exp_ffv = 1'b0; exp_ffvec = '0; exp_ffmask = '0;
    for (int i = 0; i < 4; i++) begin
      if (gap[i] >= TIMEOUT) begin
        exp_to = 1'b1;
        break;
      end
      exp_vec++;
      if (rs[i] != golden_of(ab[i])) begin
        exp_err++;
        if (!exp_ffv) begin
          exp_ffv    = 1'b1;
          exp_ffvec  = ab[i];
          exp_ffmask = rs[i] ^ golden_of(ab[i]);
        end
      end
    end

    start_pulse();
    for (int i = 0; i < 4; i++) send_gap(ab[i], rs[i], gap[i]);
    wait_done($sformatf("rnd%0d.done", run));
    check($sformatf("rnd%0d.timeout", run), timeout, exp_to);
    check($sformatf("rnd%0d.vec", run), vec_count, exp_vec);
    check($sformatf("rnd%0d.err", run), err_count, exp_err);
    check($sformatf("rnd%0d.pass", run), pass, !exp_to && exp_err == 0);
    check($sformatf("rnd%0d.ff", run), {first_fail_valid, first_fail_vec, first_fail_mask},
          {exp_ffv, exp_ffvec, exp_ffmask});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;

    tbl[0].ab = '{2'd0, 2'd1, 2'd2, 2'd3}; tbl[0].rs = '{7'h1D, 7'h3A, 7'h2A, 7'h61};
    tbl[0].err = 8'd0; tbl[0].ffv = 1'b0; tbl[0].ffvec = 2'd0; tbl[0].ffmask = 7'h00; tbl[0].pass = 1'b1;
    tbl[1].ab = '{2'd0, 2'd1, 2'd2, 2'd3}; tbl[1].rs = '{7'h1D, 7'h3A, 7'h2B, 7'h61};
    tbl[1].err = 8'd1; tbl[1].ffv = 1'b1; tbl[1].ffvec = 2'd2; tbl[1].ffmask = 7'h01; tbl[1].pass = 1'b0;
    tbl[2].ab = '{2'd0, 2'd1, 2'd2, 2'd3}; tbl[2].rs = '{7'h1C, 7'h3A, 7'h2A, 7'h60};
    tbl[2].err = 8'd2; tbl[2].ffv = 1'b1; tbl[2].ffvec = 2'd0; tbl[2].ffmask = 7'h01; tbl[2].pass = 1'b0;
    tbl[3].ab = '{2'd3, 2'd3, 2'd3, 2'd3}; tbl[3].rs = '{7'h61, 7'h61, 7'h61, 7'h61};
    tbl[3].err = 8'd0; tbl[3].ffv = 1'b0; tbl[3].ffvec = 2'd0; tbl[3].ffmask = 7'h00; tbl[3].pass = 1'b1;
    tbl[4].ab = '{2'd0, 2'd1, 2'd2, 2'd3}; tbl[4].rs = '{7'h00, 7'h00, 7'h00, 7'h00};
    tbl[4].err = 8'd4; tbl[4].ffv = 1'b1; tbl[4].ffvec = 2'd0; tbl[4].ffmask = 7'h1D; tbl[4].pass = 1'b0;
    tbl[5].ab = '{2'd3, 2'd2, 2'd1, 2'd0}; tbl[5].rs = '{7'h61, 7'h2A, 7'h3A, 7'h5D};
    tbl[5].err = 8'd1; tbl[5].ffv = 1'b1; tbl[5].ffvec = 2'd0; tbl[5].ffmask = 7'h40; tbl[5].pass = 1'b0;

    rst = 1'b1; start = 1'b0; rif.in_valid = 1'b0;
    drive(2'b00, 7'h00);
    tick();
    check_all_zero("reset.outputs");
    tick();
    rst = 1'b0;

    // in_valid in IDLE is ignored
    rif.in_valid = 1'b1;
    drive(2'b00, 7'h1D);
    tick(); tick(); tick();
    check("idle.stray", {rif.in_ready, busy, done, vec_count}, {1'b0, 1'b0, 1'b0, 8'd0});
    rif.in_valid = 1'b0;

    for (int r = 0; r < 6; r++) apply_row(r);

    // Timeout: one accepted vector, then sender goes silent
    start_pulse();
    rif.in_valid = 1'b1;
    drive(2'b00, 7'h1D);
    tick();
    rif.in_valid = 1'b0;
    tick();
    check("tmo.back_in_wait", {rif.in_ready, timeout, done}, {1'b1, 1'b0, 1'b0});
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("tmo.cycles", n, TIMEOUT);
    check("tmo.flags", {done, timeout, pass, busy}, {1'b1, 1'b1, 1'b0, 1'b0});
    check("tmo.vec", vec_count, 8'd1);

    // Reset in the middle of a run
    start_pulse();
    send_gap(2'b00, 7'h1D, 0);
    send_gap(2'b01, 7'h00, 0);
    tick();
    check("midrst.before", {vec_count, err_count}, {8'd2, 8'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst.outputs");
    apply_row(0);

    // start while busy is ignored, then restart from a failed DONE
    start_pulse();
    rif.in_valid = 1'b1;
    drive(2'b00, 7'h1C);
    tick();
    rif.in_valid = 1'b0;
    start_pulse();
    check("ign.in_check", {vec_count, err_count, busy}, {8'd1, 8'd1, 1'b1});
    start_pulse();
    check("ign.in_wait", {vec_count, first_fail_valid, busy}, {8'd1, 1'b1, 1'b1});
    send_gap(2'b01, 7'h3A, 0);
    send_gap(2'b10, 7'h2A, 0);
    send_gap(2'b11, 7'h61, 0);
    wait_done("ign.done");
    check("ign.result", {pass, err_count, first_fail_vec, first_fail_mask},
          {1'b0, 8'd1, 2'b00, 7'h01});
    start_pulse();
    check("restart.clear", {done, busy, first_fail_valid, vec_count, err_count},
          {1'b0, 1'b1, 1'b0, 8'd0, 8'd0});
    for (int i = 0; i < 4; i++) send_gap(2'(i), golden_of(2'(i)), 0);
    wait_done("restart.done");
    check("restart.result", {pass, first_fail_valid, vec_count}, {1'b1, 1'b0, 8'd4});

    for (int run = 0; run < 40; run++) random_run(run);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Response-side checker for the basic logic gate block. It accepts one sampled response per input vector over a valid/ready handshake.
- Each response carries the applied inputs a and b plus the seven gate outputs. The block compares every response against a built-in golden model.
- It counts mismatches, records the first failure, detects stalled senders, and reports a final pass/fail verdict.
- It sits between the stimulus driver and the gate block's outputs, acting as the receiving end of the exhaustive-vector gate test.

Parameters:
- NUM_VEC, 4, number of responses accepted per run before the DONE state; range 1..2^CNT_W-1.
- CNT_W, 8, width of vec_count and err_count.
- TIMEOUT, 16, maximum number of idle WAIT cycles with no transfer before the run aborts; 0 disables the timeout.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- in_valid  input  1  sender has a response on in_a, in_b and in_resp.
- in_ready  output  1  checker can accept a response; high only in WAIT.
- in_a  input  1  applied input a.
- in_b  input  1  applied input b.
- in_resp  input  7  gate outputs {AND, OR, NOT(a), NAND, NOR, XOR, XNOR}, bit 6 down to bit 0.
- busy  output  1  high in WAIT or CHECK.
- done  output  1  high in DONE; held until start or rst.
- pass  output  1  valid while done; 1 means err_count==0 and no timeout.
- timeout  output  1  run aborted because of sender inactivity.
- vec_count  output  CNT_W  number of responses accepted in this run.
- err_count  output  CNT_W  number of responses with any mismatch; saturates at 2^CNT_W-1.
- first_fail_valid  output  1  first_fail_vec and first_fail_mask hold a recorded failure.
- first_fail_vec  output  2  {a,b} of the first failing response.
- first_fail_mask  output  7  in_resp XOR expected for the first failing response.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE on the edge where rst=1.
  - rst has priority over every other input, including in the middle of a run.
  - Capture registers are cleared.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - in_ready=0.
  - start → WAIT. On the same edge, clear vec_count, err_count, first_fail_*, timeout and the idle timer.
- WAIT:
  - in_ready=1 combinationally from the state.
  - A transfer occurs when in_valid && in_ready. On a transfer, register in_a, in_b and in_resp, then → CHECK.
  - Without a transfer, the idle timer increments. When TIMEOUT≠0 and the timer reaches TIMEOUT-1 with no transfer: timeout←1, pass←0, → DONE.
  - start is ignored.
- CHECK (exactly one cycle; in_ready=0):
  - Expected value = {a&b, a|b, ~a, ~(a&b), ~(a|b), a^b, ~(a^b)}.
  - Golden values: {a,b}=00→7'h1D, 01→7'h3A, 10→7'h2A, 11→7'h61.
  - mask = captured resp ^ expected.
  - If mask≠0: err_count increments (saturating). If first_fail_valid==0, latch first_fail_vec, first_fail_mask and set first_fail_valid=1.
  - vec_count increments. The idle timer clears.
  - If the new vec_count==NUM_VEC: → DONE with pass = (final err_count==0). Otherwise → WAIT.
- DONE:
  - done=1, busy=0, in_ready=0. Result outputs are held.
  - start → WAIT with the same clearing as in IDLE; done drops on that edge.
- Throughput: maximum one response every 2 cycles.
- Handshake rules:
  - Data are sampled only on a transfer cycle.
  - When in_valid is high while in_ready is low, no data are consumed and the sender must hold its values.
  - in_ready does not depend on in_valid.
- Vector order is not enforced. Expected values are derived from the in_a and in_b delivered with each response, so repeated vectors are legal.
- Counters never wrap. err_count ≤ vec_count at all times.

Test Plan:
- Golden run: start, then send 00/1D, 01/3A, 10/2A, 11/61 with in_valid held high → in_ready pattern 1,0,1,0…; done=1, pass=1, err_count=0, vec_count=4, first_fail_valid=0.
- Single fault: as golden, but send 10/2B → err_count=1, first_fail_vec=2'b10, first_fail_mask=7'h01, pass=0, done after 4 vectors.
- Multiple faults: send 00/1C, 01/3A, 10/2A, 11/60 → err_count=2, first_fail_vec=2'b00, first_fail_mask=7'h01 (not overwritten by the second failure), pass=0.
- Timeout: start, send 00/1D, then hold in_valid=0 → done and timeout assert exactly 16 WAIT cycles after return to WAIT; vec_count=1, pass=0.
- Reset mid-run: after 2 accepted vectors (one faulty), assert rst for 1 cycle → all outputs 0, state IDLE; then start and run golden → pass=1, vec_count=4, err_count=0.
- Restart from DONE plus stray inputs: a start pulse while busy is ignored, and in_valid is ignored in IDLE and DONE. After a failing run, start again and run golden → done drops on the start edge, result pass=1, first_fail_valid=0.
